// File: rtl/cgp_grid_rt.sv
// rtl/cgp_grid_rt.sv - runtime-reconfigurable CGP grid of 4-input LUT nodes, one pipeline stage per column
module cgp_grid_rt #(
    parameter int N_IN   = 4,
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4,
    localparam int N_NODES = N_ROWS * N_COLS,
    localparam int N_SRC   = 1 + N_IN + N_ROWS * (N_COLS - 1),
    localparam int SEL_W   = $clog2(N_SRC),
    localparam int GENE_W  = 16 + 4 * SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [GENE_W-1:0] cfg_gene,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              configured,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    output logic [N_ROWS-1:0] out_data
);

    localparam int CNT_W = $clog2(N_NODES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_LOAD,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cfg_done_q, cfg_done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              configured_q, configured_d;
    logic              gene_we;
    logic              in_fire;
    int                load_col;

    logic [GENE_W-1:0] gene_q [N_NODES];

    // Pipeline: stage c holds the const/input bits plus node outputs of columns 0..c.
    // The last column only needs its own outputs, so it is kept as out_data_q.
    logic [N_COLS-1:0] vld_q, vld_d;
    logic [N_SRC-1:0]  stg_q [N_COLS-1];
    logic [N_SRC-1:0]  stg_d [N_COLS-1];
    logic [N_SRC-1:0]  prev  [N_COLS];
    logic [N_SRC-1:0]  in_vec;
    logic [N_ROWS-1:0] out_data_q, out_data_d;

    // A source is usable by a node in column col only if it is const, an input or an earlier column.
    function automatic logic src_legal(input logic [SEL_W-1:0] sel, input int col);
        return 32'(sel) < 32'(1 + N_IN + N_ROWS * col);
    endfunction

    function automatic logic gene_legal(input logic [GENE_W-1:0] g, input int col);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (!src_legal(g[16+SEL_W*j +: SEL_W], col)) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic pick(input logic [N_SRC-1:0] vec, input logic [SEL_W-1:0] sel);
        logic b;
        b = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (32'(sel) == 32'(i)) b = vec[i];
        end
        return b;
    endfunction

    // Illegal sources read as const 0 so a bad genome still evaluates deterministically.
    function automatic logic eval_node(input logic [GENE_W-1:0] g, input logic [N_SRC-1:0] vec,
                                       input int col);
        logic [3:0]       idx;
        logic [15:0]      lut;
        logic [SEL_W-1:0] sel;
        lut = g[15:0];
        for (int j = 0; j < 4; j++) begin
            sel    = g[16+SEL_W*j +: SEL_W];
            idx[j] = src_legal(sel, col) ? pick(vec, sel) : 1'b0;
        end
        return lut[idx];
    endfunction

    assign in_vec     = {{(N_SRC-1-N_IN){1'b0}}, in_data, 1'b0};
    assign cfg_ready  = (state_q == S_LOAD) && !cfg_start;
    assign in_ready   = (state_q == S_RUN);
    assign in_fire    = in_valid && in_ready;
    assign cfg_done   = cfg_done_q;
    assign cfg_err    = cfg_err_q;
    assign configured = configured_q;
    assign out_valid  = vld_q[N_COLS-1];
    assign out_data   = out_data_q;
    assign load_col   = 32'(cnt_q) / N_ROWS;

    // Controller next state: genome loading, draining before reload, and run enable.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cfg_done_d   = 1'b0;
        cfg_err_d    = cfg_err_q;
        configured_d = configured_q;
        gene_we      = 1'b0;
        if (cfg_start) begin
            configured_d = 1'b0;
            cfg_err_d    = 1'b0;
            cnt_d        = '0;
            state_d      = ((|vld_q) || in_fire) ? S_DRAIN : S_LOAD;
        end else begin
            case (state_q)
                S_DRAIN: begin
                    if (vld_q == '0) state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (cfg_valid) begin
                        gene_we = 1'b1;
                        if (!gene_legal(cfg_gene, load_col)) cfg_err_d = 1'b1;
                        if (cnt_q == CNT_W'(N_NODES - 1)) begin
                            state_d      = S_RUN;
                            cfg_done_d   = 1'b1;
                            configured_d = 1'b1;
                            cnt_d        = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            configured_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cfg_done_q   <= cfg_done_d;
            cfg_err_q    <= cfg_err_d;
            configured_q <= configured_d;
        end
    end

    // Gene store, written only while loading with an empty pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_NODES; k++) gene_q[k] <= '0;
        end else if (gene_we) begin
            gene_q[cnt_q] <= cfg_gene;
        end
    end

    // Column evaluation: each column reads the vector registered by the previous stage.
    always_comb begin
        prev[0] = in_vec;
        for (int c = 1; c < N_COLS; c++) prev[c] = stg_q[c-1];
        for (int c = 0; c < N_COLS - 1; c++) begin
            stg_d[c] = prev[c];
            for (int r = 0; r < N_ROWS; r++) begin
                stg_d[c][1+N_IN+c*N_ROWS+r] = eval_node(gene_q[c*N_ROWS+r], prev[c], c);
            end
        end
        for (int r = 0; r < N_ROWS; r++) begin
            out_data_d[r] = eval_node(gene_q[(N_COLS-1)*N_ROWS+r], prev[N_COLS-1], N_COLS - 1);
        end
        vld_d = {vld_q[N_COLS-2:0], in_fire};
    end

    // Pipeline registers advance every cycle; there is no output backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q      <= '0;
            out_data_q <= '0;
            for (int c = 0; c < N_COLS - 1; c++) stg_q[c] <= '0;
        end else begin
            vld_q      <= vld_d;
            out_data_q <= out_data_d;
            for (int c = 0; c < N_COLS - 1; c++) stg_q[c] <= stg_d[c];
        end
    end

endmodule
